// File: rtl/pk8086_pkg.sv
// Shared 8086-style definitions: physical address width, segment:offset
// translation, default reset vector and the prefetch FSM state encoding.
package pk8086_pkg;

  localparam int PHYS_W = 20;

  localparam logic [15:0] DEF_RESET_CS = 16'h0000;
  localparam logic [15:0] DEF_RESET_IP = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } pfq_state_t;

  // Physical address wraps naturally at 2^20 through the result width.
  function automatic logic [PHYS_W-1:0] seg_to_phys(input logic [15:0] seg,
                                                    input logic [15:0] off);
    return {seg, 4'h0} + {4'h0, off};
  endfunction

endpackage

// File: rtl/pfq_buffer.sv
// Circular byte store for the prefetch queue: two write lanes at consecutive
// slots starting at wr_ptr, one asynchronous read port at rd_ptr.
module pfq_buffer #(
  parameter int DEPTH = 6
) (
  input  logic                       clock,
  input  logic [$clog2(DEPTH)-1:0]   wr_ptr,
  input  logic                       wr_en0,
  input  logic                       wr_en1,
  input  logic [7:0]                 wr_data0,
  input  logic [7:0]                 wr_data1,
  input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [7:0]                 rd_data
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr1;

  // Second lane lands one slot later, wrapping at DEPTH (not a power of two).
  assign wr_ptr1 = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;

  always_ff @(posedge clock) begin
    if (wr_en0) mem[wr_ptr]  <= wr_data0;
    if (wr_en1) mem[wr_ptr1] <= wr_data1;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches 16-bit words from cs:fetch_ip into a
// byte FIFO. Optional same-cycle bypass when empty: PREFETCH_QUEUE_BYPASS_EN.
module prefetch_queue
  import pk8086_pkg::*;
#(
  parameter int          DEPTH    = 6,
  parameter logic [15:0] RESET_CS = DEF_RESET_CS,
  parameter logic [15:0] RESET_IP = DEF_RESET_IP
) (
  input  logic                       clock,
  input  logic                       locked,
  input  logic                       flush,
  input  logic [15:0]                flush_cs,
  input  logic [15:0]                flush_ip,
  output logic [PHYS_W-1:0]          o_addr,
  output logic                       o_rd,
  input  logic                       m_ready,
  input  logic [15:0]                i_data,
  output logic [7:0]                 q_byte,
  output logic                       q_valid,
  input  logic                       q_ready,
  output logic [15:0]                q_ip,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam int          PW      = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_adv(input logic [PW-1:0] p,
                                            input logic [1:0]    n);
    logic [PW-1:0] r;
    r = p;
    if (n != 2'd0) r = ptr_inc(r);
    if (n == 2'd2) r = ptr_inc(r);
    return r;
  endfunction

  pfq_state_t    state, state_nx;
  logic [15:0]   cs, fetch_ip;
  logic [PW-1:0] rd_ptr, wr_ptr;

  logic [1:0]    need, fetched, stored, need_nx;
  logic          buf_valid, pop_buf, pop, fire, byp, byp_pop;
  logic          space_ok, space_nx;
  logic [7:0]    fetch_lo, lane0, rd_data;
  logic [CW-1:0] count_nx;
  logic [15:0]   ip_nx;

  assign o_addr    = seg_to_phys(cs, fetch_ip);
  assign need      = fetch_ip[0] ? 2'd1 : 2'd2;
  assign buf_valid = (q_count != '0);
  assign pop_buf   = buf_valid && q_ready;

  // Space is judged after this cycle's pop so a full-minus-one queue can
  // still take a word while the consumer drains a byte.
  assign space_ok = (DEPTH_W - {1'b0, q_count} + {{CW{1'b0}}, pop_buf})
                    >= {{(CW-1){1'b0}}, need};

  assign fire     = o_rd && m_ready;
  assign fetched  = fire ? need : 2'd0;
  assign fetch_lo = fetch_ip[0] ? i_data[15:8] : i_data[7:0];

`ifdef PREFETCH_QUEUE_BYPASS_EN
  assign byp = !buf_valid && fire;
`else
  assign byp = 1'b0;
`endif

  assign byp_pop = byp && q_ready;
  assign stored  = fetched - {1'b0, byp_pop};
  assign lane0   = byp_pop ? i_data[15:8] : fetch_lo;

  assign q_valid = buf_valid || byp;
  assign q_byte  = buf_valid ? rd_data : (byp ? fetch_lo : 8'h00);
  assign pop     = q_valid && q_ready;

  assign count_nx = q_count + CW'(stored) - CW'(pop_buf);
  assign ip_nx    = fetch_ip + 16'(fetched);
  assign need_nx  = ip_nx[0] ? 2'd1 : 2'd2;
  assign space_nx = (DEPTH_W - {1'b0, count_nx}) >= {{(CW-1){1'b0}}, need_nx};

  pfq_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clock    (clock),
    .wr_ptr   (wr_ptr),
    .wr_en0   (stored != 2'd0),
    .wr_en1   (stored == 2'd2),
    .wr_data0 (lane0),
    .wr_data1 (i_data[15:8]),
    .rd_ptr   (rd_ptr),
    .rd_data  (rd_data)
  );

  // REQ is entered when room exists without counting on a future pop; IDLE
  // may still issue a request in a cycle whose pop frees enough room.
  always_comb begin
    o_rd     = 1'b0;
    state_nx = state;
    case (state)
      ST_REQ:  o_rd = !flush && space_ok;
      ST_IDLE: o_rd = !flush && space_ok && pop_buf;
      default: o_rd = 1'b0;
    endcase
    if (flush)                state_nx = ST_HOLD;
    else if (o_rd && !m_ready) state_nx = ST_REQ;
    else if (space_nx)         state_nx = ST_REQ;
    else                       state_nx = ST_IDLE;
  end

  always_ff @(posedge clock or negedge locked) begin
    if (!locked) begin
      state    <= ST_IDLE;
      cs       <= RESET_CS;
      fetch_ip <= RESET_IP;
      q_ip     <= RESET_IP;
      q_count  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state <= state_nx;
      if (flush) begin
        cs       <= flush_cs;
        fetch_ip <= flush_ip;
        q_ip     <= flush_ip;
        q_count  <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        fetch_ip <= ip_nx;
        q_count  <= count_nx;
        if (pop) q_ip <= q_ip + 16'd1;
        rd_ptr   <= ptr_adv(rd_ptr, {1'b0, pop_buf});
        wr_ptr   <= ptr_adv(wr_ptr, stored);
      end
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed vector bench for prefetch_queue (DEPTH=6, reset vector 0000:0000).
module tb_prefetch_queue;

  logic        clock = 1'b0;
  logic        locked, flush, m_ready, q_ready;
  logic [15:0] flush_cs, flush_ip, i_data;
  logic [19:0] o_addr;
  logic        o_rd, q_valid;
  logic [7:0]  q_byte;
  logic [15:0] q_ip;
  logic [2:0]  q_count;

  int total = 0;
  int bad   = 0;

`ifdef PREFETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  prefetch_queue dut (
    .clock    (clock),
    .locked   (locked),
    .flush    (flush),
    .flush_cs (flush_cs),
    .flush_ip (flush_ip),
    .o_addr   (o_addr),
    .o_rd     (o_rd),
    .m_ready  (m_ready),
    .i_data   (i_data),
    .q_byte   (q_byte),
    .q_valid  (q_valid),
    .q_ready  (q_ready),
    .q_ip     (q_ip),
    .q_count  (q_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        fl;
    logic [15:0] fcs;
    logic [15:0] fip;
    logic        mr;
    logic        qr;
    logic [15:0] dat;
    logic        e_rd;
    logic [19:0] e_addr;
    logic        e_qv;
    logic [7:0]  e_qb;
    logic [15:0] e_qip;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fl, input logic [15:0] fcs, input logic [15:0] fip,
                     input logic mr, input logic qr, input logic [15:0] dat,
                     input logic e_rd, input logic [19:0] e_addr, input logic e_qv,
                     input logic [7:0] e_qb, input logic [15:0] e_qip, input logic [2:0] e_cnt);
    vec_t v;
    v.fl = fl; v.fcs = fcs; v.fip = fip; v.mr = mr; v.qr = qr; v.dat = dat;
    v.e_rd = e_rd; v.e_addr = e_addr; v.e_qv = e_qv; v.e_qb = e_qb;
    v.e_qip = e_qip; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin
    locked = 1'b0; flush = 1'b0; flush_cs = '0; flush_ip = '0;
    m_ready = 1'b0; q_ready = 1'b0; i_data = '0;

    //   fl fcs      fip      mr qr data      rd addr      qv                 qb                        qip      cnt
    add(0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 20'h00000, 0,                 8'h00,                    16'h0000, 3'd0);
    add(0, 16'h0000, 16'h0000, 1, 0, 16'h1100, 1, 20'h00000, BYP,               8'h00,                    16'h0000, 3'd0);
    add(0, 16'h0000, 16'h0000, 1, 0, 16'h3322, 1, 20'h00002, 1,                 8'h00,                    16'h0000, 3'd2);
    add(0, 16'h0000, 16'h0000, 1, 0, 16'h5544, 1, 20'h00004, 1,                 8'h00,                    16'h0000, 3'd4);
    add(0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 20'h00006, 1,                 8'h00,                    16'h0000, 3'd6);
    add(0, 16'h0000, 16'h0000, 1, 1, 16'h0000, 0, 20'h00006, 1,                 8'h00,                    16'h0000, 3'd6);
    add(0, 16'h0000, 16'h0000, 1, 1, 16'h7766, 1, 20'h00006, 1,                 8'h11,                    16'h0001, 3'd5);
    add(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 20'h00008, 1,                 8'h22,                    16'h0002, 3'd6);
    add(0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 0, 20'h00008, 1,                 8'h22,                    16'h0002, 3'd6);
    add(0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 1, 20'h00008, 1,                 8'h33,                    16'h0003, 3'd5);
    add(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 20'h00008, 1,                 8'h44,                    16'h0004, 3'd4);
    add(1, 16'h1000, 16'h0003, 1, 1, 16'h9988, 0, 20'h00008, 1,                 8'h44,                    16'h0004, 3'd4);
    add(0, 16'h0000, 16'h0000, 1, 1, 16'hAABB, 0, 20'h10003, 0,                 8'h00,                    16'h0003, 3'd0);
    add(0, 16'h0000, 16'h0000, 1, 0, 16'hCCDD, 1, 20'h10003, BYP,               BYP ? 8'hCC : 8'h00,      16'h0003, 3'd0);
    add(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 20'h10004, 1,                 8'hCC,                    16'h0003, 3'd1);
    add(0, 16'h0000, 16'h0000, 1, 1, 16'hEEFF, 1, 20'h10004, 1,                 8'hCC,                    16'h0003, 3'd1);
    add(0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 1, 20'h10006, 1,                 8'hFF,                    16'h0004, 3'd2);
    add(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 20'h10006, 1,                 8'hEE,                    16'h0005, 3'd1);
    add(1, 16'hF000, 16'hFFFF, 1, 0, 16'h0000, 0, 20'h10006, 1,                 8'hEE,                    16'h0005, 3'd1);
    add(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 20'hFFFFF, 0,                 8'h00,                    16'hFFFF, 3'd0);
    add(0, 16'h0000, 16'h0000, 1, 0, 16'h1234, 1, 20'hFFFFF, BYP,               BYP ? 8'h12 : 8'h00,      16'hFFFF, 3'd0);
    add(0, 16'h0000, 16'h0000, 1, 0, 16'h5678, 1, 20'hF0000, 1,                 8'h12,                    16'hFFFF, 3'd1);
    add(0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 1, 20'hF0002, 1,                 8'h12,                    16'hFFFF, 3'd3);
    add(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 20'hF0002, 1,                 8'h78,                    16'h0000, 3'd2);

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst o_rd",    32'(o_rd),    32'h0);
    chk("rst q_valid", 32'(q_valid), 32'h0);
    chk("rst q_count", 32'(q_count), 32'h0);
    chk("rst q_byte",  32'(q_byte),  32'h0);
    chk("rst q_ip",    32'(q_ip),    32'h0);
    chk("rst o_addr",  32'(o_addr),  32'h0);
    locked = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      flush = vecs[i].fl; flush_cs = vecs[i].fcs; flush_ip = vecs[i].fip;
      m_ready = vecs[i].mr; q_ready = vecs[i].qr; i_data = vecs[i].dat;
      #1;
      chk($sformatf("v%0d o_rd", i),    32'(o_rd),    32'(vecs[i].e_rd));
      chk($sformatf("v%0d o_addr", i),  32'(o_addr),  32'(vecs[i].e_addr));
      chk($sformatf("v%0d q_valid", i), 32'(q_valid), 32'(vecs[i].e_qv));
      chk($sformatf("v%0d q_byte", i),  32'(q_byte),  32'(vecs[i].e_qb));
      chk($sformatf("v%0d q_ip", i),    32'(q_ip),    32'(vecs[i].e_qip));
      chk($sformatf("v%0d q_count", i), 32'(q_count), 32'(vecs[i].e_cnt));
      @(negedge clock);
    end

    // Reset dropped while a request is outstanding.
    flush = 1'b0; m_ready = 1'b0; q_ready = 1'b0;
    locked = 1'b0;
    #1;
    chk("midrst o_rd",    32'(o_rd),    32'h0);
    chk("midrst q_valid", 32'(q_valid), 32'h0);
    chk("midrst q_count", 32'(q_count), 32'h0);
    chk("midrst q_byte",  32'(q_byte),  32'h0);
    chk("midrst q_ip",    32'(q_ip),    32'h0);
    chk("midrst o_addr",  32'(o_addr),  32'h0);
    @(negedge clock);
    locked = 1'b1; m_ready = 1'b1; q_ready = 1'b1; i_data = 16'hA1B2;
    #1;
    chk("relock o_rd pre-edge", 32'(o_rd), 32'h0);
    @(negedge clock);
    #1;
    chk("relock o_rd",    32'(o_rd),    32'h1);
    chk("relock o_addr",  32'(o_addr),  32'h0);
    chk("same-cycle q_valid", 32'(q_valid), BYP ? 32'h1 : 32'h0);
    if (BYP) chk("bypass q_byte", 32'(q_byte), 32'hB2);
    @(negedge clock);
    m_ready = 1'b0; q_ready = 1'b0;
    #1;
    chk("after-push q_count", 32'(q_count), BYP ? 32'h1 : 32'h2);
    chk("after-push q_byte",  32'(q_byte),  BYP ? 32'hA1 : 32'hB2);
    chk("after-push q_ip",    32'(q_ip),    BYP ? 32'h1 : 32'h0);
    chk("after-push q_valid", 32'(q_valid), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 6, meaning queue capacity in bytes (legal range 4..16).
REQ-002 SHALL have parameter RESET_CS, default 16'h0000, meaning the code segment loaded at reset.
REQ-003 SHALL have parameter RESET_IP, default 16'h0000, meaning the instruction pointer loaded at reset.
REQ-004 SHALL have port clock  in  1  system clock, rising edge.
REQ-005 SHALL have port locked  in  1  asynchronous active-low reset (0 = PLL not locked, block held in reset).
REQ-006 SHALL have port flush  in  1  discard queue and restart fetch at flush_cs:flush_ip.
REQ-007 SHALL have ports flush_cs  in  16  and flush_ip  in  16, the new fetch target, sampled when flush=1.
REQ-008 SHALL have port o_addr  out  20  physical fetch address, {cs,4'h0}+fetch_ip mod 2^20.
REQ-009 SHALL have port o_rd  out  1  fetch request.
REQ-010 SHALL have port m_ready  in  1  memory data valid for the current request.
REQ-011 SHALL have port i_data  in  16  memory word; the byte at even address is [7:0], at odd address [15:8].
REQ-012 SHALL have port q_byte  out  8  oldest queued byte.
REQ-013 SHALL have port q_valid  out  1  q_byte valid.
REQ-014 SHALL have port q_ready  in  1  consumer takes q_byte.
REQ-015 SHALL have port q_ip  out  16  IP of q_byte.
REQ-016 SHALL have port q_count  out  $clog2(DEPTH+1)  bytes held.

Function
REQ-017 A pop SHALL occur when q_valid&&q_ready; q_ip SHALL then increment by 1, mod 2^16.
REQ-018 A fetch SHALL be even (fetch_ip[0]=0, 2 bytes) or odd (fetch_ip[0]=1, only [15:8], 1 byte).
REQ-019 o_rd SHALL assert only when free space after this cycle's pop is >= bytes of the next fetch.
REQ-020 o_addr SHALL remain stable while o_rd=1 and m_ready=0.
REQ-021 In a cycle with o_rd=1 and m_ready=1, the fetched bytes SHALL be written in ascending address order.
REQ-022 In the same cycle, fetch_ip SHALL advance by the fetched byte count.
REQ-023 Push and pop in the same cycle SHALL both take effect; q_count SHALL change by pushed-minus-popped.
REQ-024 fetch_ip SHALL wrap FFFF->0000 within the segment, and the physical address SHALL wrap at 2^20.
REQ-025 flush SHALL have priority over push and pop: count=0, q_valid=0 next cycle, cs/fetch_ip/q_ip loaded from flush inputs.
REQ-026 i_data accepted in the flush cycle SHALL be discarded.
REQ-027 o_rd SHALL deassert in the flush cycle and may reassert with the new address from the next cycle.
REQ-028 Full (count=DEPTH): o_rd=0. Empty: q_valid=0. Internal read/write pointers SHALL wrap modulo DEPTH.
REQ-029 Control SHALL be a 3-state FSM: IDLE (no space), REQ (o_rd=1, waiting m_ready), HOLD (one cycle after flush, o_rd=0).

Reset
REQ-030 While locked=0, the block SHALL hold: o_rd=0, q_valid=0, q_count=0, q_byte=8'h00, cs=RESET_CS, fetch_ip=q_ip=RESET_IP, FSM=IDLE.
REQ-031 Reset asserted mid-request SHALL abandon the request; first o_rd SHALL follow the first clock edge after locked rises.

Configuration
REQ-032 With macro PREFETCH_QUEUE_BYPASS_EN defined: when empty, a byte arriving with m_ready SHALL appear on q_byte/q_valid combinationally in the same cycle.
REQ-033 With the bypass macro defined: if popped in that cycle, that byte SHALL NOT be stored.
REQ-034 Without the macro: a byte SHALL first be visible on the cycle after its write (minimum latency 1).

Structure
REQ-035 Shared package pk8086_pkg SHALL hold PHYS_W=20, the segment:offset-to-physical function, and the default reset vector constants.
REQ-036 Byte storage SHALL be sub-module pfq_buffer (circular, 2 write lanes, 1 read port, DEPTH parameter); FSM and pointers SHALL stay in prefetch_queue.

Verification
REQ-037 Reset, q_ready=0, m_ready=1 always: o_addr 00000, 00002, 00004; then o_rd=0 with q_count=6.
REQ-038 flush_cs=1000, flush_ip=0003: first fetch o_addr=10003 takes [15:8] only, next o_addr=10004, q_ip=0003.
REQ-039 flush during REQ with m_ready=1 same cycle: data discarded, q_count=0 next cycle, o_rd=0 for one cycle.
REQ-040 fetch_ip=FFFF, cs=F000: fetch FFFFF (1 byte), then 0F000.0 wraps to F0000; q_ip FFFF->0000.
REQ-041 Full queue, simultaneous pop and 2-byte push not allowed (REQ-019); count=5 with pop + 2-byte push -> count=6.
REQ-042 PREFETCH_QUEUE_BYPASS_EN: empty, m_ready=1, q_ready=1: byte consumed same cycle, q_count=1 (second byte only).
